// File: rtl/hbm_cmd_arbiter.sv
// hbm_cmd_arbiter: shares one HBM controller command/write channel and read
// channel among NUM_REQ cores. Round-robin command arbitration feeds a
// registered output stage; an in-order ID FIFO steers read beats back to the
// core that issued each read.
// Optional feature: define HBM_ARB_PERF_CNT_EN to build per-core 32-bit grant
// counters on o_grant_cnt; otherwise o_grant_cnt is tied to zero.
module hbm_cmd_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int CMD_W         = 23,
  parameter int DATA_W        = 1024,
  parameter int RD_FIFO_DEPTH = 16,
  localparam int CNT_W        = $clog2(RD_FIFO_DEPTH) + 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [NUM_REQ-1:0]      i_cmd_valid,
  output logic [NUM_REQ-1:0]      o_cmd_ready,
  input  logic [NUM_REQ*CMD_W-1:0]  i_cmd,
  input  logic [NUM_REQ*DATA_W-1:0] i_wr_data,
  output logic [NUM_REQ-1:0]      o_rd_valid,
  input  logic [NUM_REQ-1:0]      i_rd_ready,
  output logic [DATA_W-1:0]       o_rd_data,
  output logic                    m_axis_wr_tvalid,
  input  logic                    m_axis_wr_tready,
  output logic [DATA_W-1:0]       m_axis_wr_tdata,
  output logic [CMD_W-1:0]        m_axis_wr_tuser,
  output logic [DATA_W/8-1:0]     m_axis_wr_tkeep,
  output logic                    m_axis_wr_tlast,
  input  logic                    s_axis_rd_tvalid,
  output logic                    s_axis_rd_tready,
  input  logic [DATA_W-1:0]       s_axis_rd_tdata,
  output logic [CNT_W-1:0]        o_rd_outstanding,
  output logic                    o_err_orphan,
  output logic [NUM_REQ*32-1:0]   o_grant_cnt
);

  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);

  logic                slot_free;
  logic                fifo_full;
  logic                fifo_empty;
  logic [NUM_REQ-1:0]  eligible;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     search_idx;
  logic [CMD_W-1:0]    grant_cmd;
  logic [DATA_W-1:0]   grant_data;
  logic                push;
  logic                pop;
  logic [ID_W-1:0]     head_id;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [ID_W-1:0]     fifo_mem [RD_FIFO_DEPTH];
  logic                tvalid_q;
  logic [DATA_W-1:0]   tdata_q;
  logic [CMD_W-1:0]    tuser_q;
  logic                orphan_q;

  assign slot_free  = !tvalid_q || m_axis_wr_tready;
  // Full is taken from the registered count, so a same-cycle pop never admits a read.
  assign fifo_full  = (count_q == CNT_W'(RD_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_mem[rd_ptr_q];

  // A core may compete when it has a command and, for reads, an ID FIFO slot.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = i_cmd_valid[k] && (i_cmd[k*CMD_W + CMD_W-1] || !fifo_full);
    end
  end

  // Round-robin search from rr_q upward, wrapping; first eligible core wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    search_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      search_idx = ID_W'((int'(rr_q) + i) % NUM_REQ);
      if (slot_free && !grant_vld && eligible[search_idx]) begin
        grant_vld = 1'b1;
        grant_idx = search_idx;
      end
    end
  end

  // Select the winner's command and write data, and raise its ready bit.
  always_comb begin
    grant_cmd   = '0;
    grant_data  = '0;
    o_cmd_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        grant_cmd  = i_cmd[k*CMD_W +: CMD_W];
        grant_data = i_wr_data[k*DATA_W +: DATA_W];
      end
    end
    if (grant_vld) o_cmd_ready[grant_idx] = 1'b1;
  end

  // Pointer advance, FIFO push/pop and occupancy next state.
  always_comb begin
    rr_d = rr_q;
    if (grant_vld) rr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    push    = grant_vld && !grant_cmd[CMD_W-1];
    pop     = s_axis_rd_tvalid && s_axis_rd_tready;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Read return is steered to the core recorded at the FIFO head.
  always_comb begin
    o_rd_valid = '0;
    if (s_axis_rd_tvalid && !fifo_empty) o_rd_valid[head_id] = 1'b1;
    s_axis_rd_tready = !fifo_empty && i_rd_ready[head_id];
  end

  // Registered command stage: load on grant, hold until accepted, then drop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
    end else if (grant_vld) begin
      tvalid_q <= 1'b1;
      tdata_q  <= grant_data;
      tuser_q  <= grant_cmd;
    end else if (m_axis_wr_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  // Arbitration pointer, FIFO pointers/occupancy and the sticky orphan flag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_q     <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (s_axis_rd_tvalid && fifo_empty) orphan_q <= 1'b1;
    end
  end

  // ID storage for outstanding reads.
  // NOTE: the ID array has no reset; entries are only read when the count says they are valid.
  always_ff @(posedge ap_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= grant_idx;
  end

`ifdef HBM_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q [NUM_REQ];

  // Per-core grant counters, free-running with natural 32-bit wrap.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) grant_cnt_q[k] <= '0;
    end else if (grant_vld) begin
      grant_cnt_q[grant_idx] <= grant_cnt_q[grant_idx] + 32'd1;
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) o_grant_cnt[k*32 +: 32] = grant_cnt_q[k];
  end
`else
  assign o_grant_cnt = '0;
`endif

  assign m_axis_wr_tvalid = tvalid_q;
  assign m_axis_wr_tdata  = tdata_q;
  assign m_axis_wr_tuser  = tuser_q;
  assign m_axis_wr_tkeep  = '1;
  assign m_axis_wr_tlast  = 1'b0;
  assign o_rd_data        = s_axis_rd_tdata;
  assign o_rd_outstanding = count_q;
  assign o_err_orphan     = orphan_q;

endmodule
